// File: rtl/accel_tile_sequencer.sv
// Tile sequencer: moves weights/activations from shared SRAM into the tile buffers,
// preloads and drives the PE array, and writes results into the output buffer.
module accel_tile_sequencer #(
   parameter int N      = 16,
   parameter int PE_LAT = 31,
   parameter int IA_W   = 13,
   parameter int OA_W   = 17,
   parameter int CNT_W  = 8
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             start,
   input  logic [CNT_W-1:0] cfg_len,
   input  logic             cfg_reuse_w,
   input  logic             OPSEL,
   input  logic [IA_W-1:0]  IADDR,
   input  logic [IA_W-1:0]  WADDR,
   input  logic [OA_W-1:0]  OADDR,
   output logic             busy,
   output logic             done,
   output logic [2:0]       STATE,
   output logic             share_cen,
   output logic [IA_W-1:0]  share_addr,
   output logic             weight_cen,
   output logic             weight_wen,
   output logic [IA_W-1:0]  weight_addr,
   output logic             input_cen,
   output logic             input_wen,
   output logic [IA_W-1:0]  input_addr,
   output logic             output_cen,
   output logic             output_wen,
   output logic [OA_W-1:0]  output_addr,
   output logic             pe_w_en,
   output logic             pe_en,
   output logic             pe_opsel,
   input  logic             ext_cen,
   input  logic             ext_wen,
   input  logic [OA_W-1:0]  ext_addr,
   output logic             ext_grant
);

   localparam int LMAX = (1 << CNT_W) - 1;
   localparam int MAXC = (LMAX + PE_LAT > N) ? LMAX + PE_LAT : N;
   localparam int CW   = $clog2(MAXC + 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOADW   = 3'd1,
      S_LOADI   = 3'd2,
      S_PRELOAD = 3'd3,
      S_COMPUTE = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0] len_q;
   logic             reuse_q, opsel_q;
   logic [IA_W-1:0]  iaddr_q, waddr_q;
   logic [OA_W-1:0]  oaddr_q;

   // Tile configuration seen by the decoders: the live inputs on the accepting cycle.
   logic             accept;
   logic [CW-1:0]    len_e, last_e;
   logic [IA_W-1:0]  iaddr_e, waddr_e;
   logic [OA_W-1:0]  oaddr_e;

   assign accept  = (state_q == S_IDLE) && start;
   assign len_e   = (state_q == S_IDLE) ? CW'(cfg_len) : CW'(len_q);
   assign iaddr_e = (state_q == S_IDLE) ? IADDR : iaddr_q;
   assign waddr_e = (state_q == S_IDLE) ? WADDR : waddr_q;
   assign oaddr_e = (state_q == S_IDLE) ? OADDR : oaddr_q;
   assign last_e  = len_e + CW'(PE_LAT);

   // ---------------- state register ----------------
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         len_q   <= '0;
         reuse_q <= 1'b0;
         opsel_q <= 1'b0;
         iaddr_q <= '0;
         waddr_q <= '0;
         oaddr_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            len_q   <= cfg_len;
            reuse_q <= cfg_reuse_w;
            opsel_q <= OPSEL;
            iaddr_q <= IADDR;
            waddr_q <= WADDR;
            oaddr_q <= OADDR;
         end
      end
   end

   // ---------------- next-state logic ----------------
   // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (start) begin
               if (cfg_len == '0)   state_d = S_DONE;
               else if (cfg_reuse_w) state_d = S_LOADI;
               else                  state_d = S_LOADW;
            end
         end
         S_LOADW: if (cnt_q == CW'(N)) begin
            state_d = S_LOADI;
            cnt_d   = '0;
         end
         S_LOADI: if (cnt_q == CW'(len_q)) begin
            state_d = reuse_q ? S_COMPUTE : S_PRELOAD;
            cnt_d   = '0;
         end
         S_PRELOAD: if (cnt_q == CW'(N)) begin
            state_d = S_COMPUTE;
            cnt_d   = '0;
         end
         S_COMPUTE: if (cnt_q == last_e) begin
            state_d = S_DONE;
            cnt_d   = '0;
         end
         S_DONE: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // ---------------- output decode (from next state/count) ----------------
   logic            busy_d, done_d, grant_d, pe_w_en_d, pe_en_d;
   logic            share_cen_d, weight_cen_d, weight_wen_d, input_cen_d, input_wen_d;
   logic            out_cen_d, out_wen_d;
   logic [IA_W-1:0] share_addr_d, weight_addr_d, input_addr_d;
   logic [OA_W-1:0] out_addr_d;

   always_comb begin
      busy_d        = 1'b0;
      done_d        = 1'b0;
      grant_d       = 1'b0;
      pe_w_en_d     = 1'b0;
      pe_en_d       = 1'b0;
      share_cen_d   = 1'b1;
      share_addr_d  = '0;
      weight_cen_d  = 1'b1;
      weight_wen_d  = 1'b1;
      weight_addr_d = '0;
      input_cen_d   = 1'b1;
      input_wen_d   = 1'b1;
      input_addr_d  = '0;
      out_cen_d     = 1'b1;
      out_wen_d     = 1'b1;
      out_addr_d    = '0;
      case (state_d)
         S_IDLE: grant_d = 1'b1;
         S_LOADW: begin
            busy_d = 1'b1;
            if (cnt_d < CW'(N)) begin
               share_cen_d  = 1'b0;
               share_addr_d = waddr_e + IA_W'(cnt_d);
            end
            if (cnt_d != '0) begin
               weight_cen_d  = 1'b0;
               weight_wen_d  = 1'b0;
               weight_addr_d = IA_W'(cnt_d - CW'(1));
            end
         end
         S_LOADI: begin
            busy_d = 1'b1;
            if (cnt_d < len_e) begin
               share_cen_d  = 1'b0;
               share_addr_d = iaddr_e + IA_W'(cnt_d);
            end
            if (cnt_d != '0) begin
               input_cen_d  = 1'b0;
               input_wen_d  = 1'b0;
               input_addr_d = IA_W'(cnt_d - CW'(1));
            end
         end
         S_PRELOAD: begin
            busy_d = 1'b1;
            if (cnt_d < CW'(N)) begin
               weight_cen_d  = 1'b0;
               weight_addr_d = IA_W'(cnt_d);
            end
            pe_w_en_d = (cnt_d != '0);
         end
         S_COMPUTE: begin
            busy_d  = 1'b1;
            pe_en_d = (cnt_d != '0);
            if (cnt_d < len_e) begin
               input_cen_d  = 1'b0;
               input_addr_d = IA_W'(cnt_d);
            end
            // Array results emerge PE_LAT cycles after the first pe_en, one per vector.
            if (cnt_d > CW'(PE_LAT) && cnt_d <= last_e) begin
               out_cen_d  = 1'b0;
               out_wen_d  = 1'b0;
               out_addr_d = oaddr_e + OA_W'(cnt_d - CW'(PE_LAT + 1));
            end
         end
         S_DONE: begin
            done_d  = 1'b1;
            grant_d = 1'b1;
         end
         default: grant_d = 1'b1;
      endcase
   end

   // ---------------- output registers ----------------
   logic            out_cen_q, out_wen_q;
   logic [OA_W-1:0] out_addr_q;

   // NOTE: outputs are decoded from next state and registered, so they line up with STATE.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         busy        <= 1'b0;
         done        <= 1'b0;
         ext_grant   <= 1'b1;
         pe_w_en     <= 1'b0;
         pe_en       <= 1'b0;
         share_cen   <= 1'b1;
         share_addr  <= '0;
         weight_cen  <= 1'b1;
         weight_wen  <= 1'b1;
         weight_addr <= '0;
         input_cen   <= 1'b1;
         input_wen   <= 1'b1;
         input_addr  <= '0;
         out_cen_q   <= 1'b1;
         out_wen_q   <= 1'b1;
         out_addr_q  <= '0;
      end else begin
         busy        <= busy_d;
         done        <= done_d;
         ext_grant   <= grant_d;
         pe_w_en     <= pe_w_en_d;
         pe_en       <= pe_en_d;
         share_cen   <= share_cen_d;
         share_addr  <= share_addr_d;
         weight_cen  <= weight_cen_d;
         weight_wen  <= weight_wen_d;
         weight_addr <= weight_addr_d;
         input_cen   <= input_cen_d;
         input_wen   <= input_wen_d;
         input_addr  <= input_addr_d;
         out_cen_q   <= out_cen_d;
         out_wen_q   <= out_wen_d;
         out_addr_q  <= out_addr_d;
      end
   end

   assign STATE    = state_q;
   assign pe_opsel = opsel_q;

   // External port owns the output buffer combinationally whenever it holds the grant.
   assign output_cen  = ext_grant ? ext_cen  : out_cen_q;
   assign output_wen  = ext_grant ? ext_wen  : out_wen_q;
   assign output_addr = ext_grant ? ext_addr : out_addr_q;

endmodule
